// File: rtl/branch_resolve_ctrl_if.sv
// Redirect handshake between the EX-stage resolution controller and fetch.
//   valid : controller requests a redirect (held until ready)
//   pc    : correct next PC, stable while valid is high and ready is low
//   ready : fetch accepts the redirect
// master : controller side (drives valid/pc, samples ready)
// slave  : fetch side (samples valid/pc, drives ready)
interface branch_resolve_ctrl_if #(
  parameter int unsigned XLEN = 64
);
  logic            valid;
  logic [XLEN-1:0] pc;
  logic            ready;

  modport master (
    output valid,
    output pc,
    input  ready
  );

  modport slave (
    input  valid,
    input  pc,
    output ready
  );
endinterface

// File: rtl/branch_resolve_ctrl.sv
// EX-stage control-transfer resolution controller.
// Resolves BEQ/BNE/BLT/BGE/BLTU/BGEU, JAL and JALR, compares the outcome with the
// fetch prediction, and on a mispredict runs a redirect handshake to fetch while
// flushing IF/ID and ID/EX and stalling EX. Owns the 2-bit PHT read by fetch and
// two saturating performance counters.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   ex_valid, ex_is_*           EX instruction valid and class
//   ex_funct3                   branch condition code
//   ex_rs1_data, ex_rs2_data    forwarded operands
//   ex_pc, ex_imm               instruction PC and sign-extended immediate
//   ex_pred_taken/target        prediction carried down from fetch
//   if_pc, if_pred_taken        fetch-side PHT lookup (combinational)
//   redirect                    redirect handshake (master side)
//   flush_if_id, flush_id_ex    squash pipeline registers
//   ex_stall                    hold EX and earlier stages
//   br_count, mispredict_count  saturating 32-bit event counters
module branch_resolve_ctrl #(
  parameter int unsigned XLEN         = 64,
  parameter int unsigned PHT_ENTRIES  = 64,
  parameter int unsigned DRAIN_CYCLES = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         ex_valid,
  input  logic                         ex_is_branch,
  input  logic                         ex_is_jal,
  input  logic                         ex_is_jalr,
  input  logic [2:0]                   ex_funct3,
  input  logic [XLEN-1:0]              ex_rs1_data,
  input  logic [XLEN-1:0]              ex_rs2_data,
  input  logic [XLEN-1:0]              ex_pc,
  input  logic [XLEN-1:0]              ex_imm,
  input  logic                         ex_pred_taken,
  input  logic [XLEN-1:0]              ex_pred_target,
  input  logic [XLEN-1:0]              if_pc,
  output logic                         if_pred_taken,
  branch_resolve_ctrl_if.master        redirect,
  output logic                         flush_if_id,
  output logic                         flush_id_ex,
  output logic                         ex_stall,
  output logic [31:0]                  br_count,
  output logic [31:0]                  mispredict_count
);

  localparam int unsigned IdxW   = $clog2(PHT_ENTRIES);
  localparam int unsigned DrainW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DrainW-1:0] DrainLoad =
      DrainW'((DRAIN_CYCLES > 0) ? (DRAIN_CYCLES - 1) : 0);

  localparam logic [1:0] StIdle     = 2'd0;
  localparam logic [1:0] StRedirect = 2'd1;
  localparam logic [1:0] StDrain    = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [DrainW-1:0] drain_q, drain_d;
  logic [XLEN-1:0]   redirect_pc_q, redirect_pc_d;
  logic              redirect_valid_q;
  logic              busy_q;
  logic [31:0]       br_count_q, mispredict_count_q;
  logic [1:0]        pht_q [PHT_ENTRIES];
  logic              redirect_ready;

  // ---------------------------------------------------------------------------
  // Resolution datapath
  // ---------------------------------------------------------------------------
  logic            resolve;
  logic            cond_true;
  logic            taken;
  logic [XLEN-1:0] pc_plus_imm;
  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] seq_pc;
  logic [XLEN-1:0] actual_next;
  logic            mispredict;

  assign redirect_ready = redirect.ready;

  // EX is stalled outside IDLE, so ex_valid is only meaningful there.
  assign resolve = ex_valid & (ex_is_branch | ex_is_jal | ex_is_jalr) & (state_q == StIdle);

  always_comb begin
    cond_true = 1'b0;
    unique case (ex_funct3)
      3'b000:  cond_true = (ex_rs1_data == ex_rs2_data);
      3'b001:  cond_true = (ex_rs1_data != ex_rs2_data);
      3'b100:  cond_true = ($signed(ex_rs1_data) <  $signed(ex_rs2_data));
      3'b101:  cond_true = ($signed(ex_rs1_data) >= $signed(ex_rs2_data));
      3'b110:  cond_true = (ex_rs1_data <  ex_rs2_data);
      3'b111:  cond_true = (ex_rs1_data >= ex_rs2_data);
      default: cond_true = 1'b0;
    endcase
  end

  assign taken       = ex_is_jal | ex_is_jalr | (ex_is_branch & cond_true);
  assign pc_plus_imm = ex_pc + ex_imm;
  assign jalr_sum    = ex_rs1_data + ex_imm;
  assign target      = ex_is_jalr ? {jalr_sum[XLEN-1:1], 1'b0} : pc_plus_imm;
  assign seq_pc      = ex_pc + XLEN'(4);
  assign actual_next = taken ? target : seq_pc;
  assign mispredict  = (taken != ex_pred_taken) | (taken & (ex_pred_target != target));

  // ---------------------------------------------------------------------------
  // Pattern history table
  // ---------------------------------------------------------------------------
  logic [IdxW-1:0] ex_idx;
  logic [IdxW-1:0] if_idx;
  logic [1:0]      pht_old;
  logic [1:0]      pht_new;

  assign ex_idx  = ex_pc[IdxW+1:2];
  assign if_idx  = if_pc[IdxW+1:2];
  assign pht_old = pht_q[ex_idx];

  always_comb begin
    pht_new = pht_old;
    if (taken) begin
      if (pht_old != 2'b11) pht_new = pht_old + 2'b01;
    end else begin
      if (pht_old != 2'b00) pht_new = pht_old - 2'b01;
    end
  end

  // Reads the registered array, so a same-cycle update is not yet visible.
  assign if_pred_taken = pht_q[if_idx][1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(PHT_ENTRIES); i++) pht_q[i] <= 2'b01;
    end else if (resolve && ex_is_branch) begin
      pht_q[ex_idx] <= pht_new;
    end
  end

  // ---------------------------------------------------------------------------
  // Redirect FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    drain_d       = drain_q;
    redirect_pc_d = redirect_pc_q;
    case (state_q)
      StIdle: begin
        if (resolve && mispredict) begin
          state_d       = StRedirect;
          redirect_pc_d = actual_next;
        end
      end
      StRedirect: begin
        if (redirect_ready) begin
          if (DRAIN_CYCLES == 0) begin
            state_d = StIdle;
          end else begin
            state_d = StDrain;
            drain_d = DrainLoad;
          end
        end
      end
      StDrain: begin
        if (drain_q == '0) state_d = StIdle;
        else               drain_d = drain_q - DrainW'(1);
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= StIdle;
      drain_q          <= '0;
      redirect_pc_q    <= '0;
      redirect_valid_q <= 1'b0;
      busy_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      drain_q          <= drain_d;
      redirect_pc_q    <= redirect_pc_d;
      redirect_valid_q <= (state_d == StRedirect);
      busy_q           <= (state_d != StIdle);
    end
  end

  // ---------------------------------------------------------------------------
  // Performance counters (saturating)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_count_q         <= '0;
      mispredict_count_q <= '0;
    end else if (resolve) begin
      if (br_count_q != '1) br_count_q <= br_count_q + 32'd1;
      if (mispredict && (mispredict_count_q != '1)) begin
        mispredict_count_q <= mispredict_count_q + 32'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign redirect.valid   = redirect_valid_q;
  assign redirect.pc      = redirect_pc_q;
  assign flush_if_id      = busy_q;
  assign flush_id_ex      = busy_q;
  assign ex_stall         = busy_q;
  assign br_count         = br_count_q;
  assign mispredict_count = mispredict_count_q;

  // Only the index bits of if_pc take part in the lookup.
  logic unused_if_pc;
  assign unused_if_pc = ^{if_pc[XLEN-1:IdxW+2], if_pc[1:0]};

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Self-checking bench for branch_resolve_ctrl: directed scenarios plus a randomized
// stream, checked against a behavioural model of the resolution rules.
module tb_branch_resolve_ctrl;
  localparam int unsigned XLEN = 64;
  localparam int unsigned NENT = 64;
  localparam int unsigned DRN  = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            ex_valid, ex_is_branch, ex_is_jal, ex_is_jalr;
  logic [2:0]      ex_funct3;
  logic [XLEN-1:0] ex_rs1_data, ex_rs2_data, ex_pc, ex_imm, ex_pred_target, if_pc;
  logic            ex_pred_taken;
  logic            if_pred_taken;
  logic            flush_if_id, flush_id_ex, ex_stall;
  logic [31:0]     br_count, mispredict_count;

  branch_resolve_ctrl_if #(.XLEN(XLEN)) rif ();

  branch_resolve_ctrl #(.XLEN(XLEN), .PHT_ENTRIES(NENT), .DRAIN_CYCLES(DRN)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .ex_valid         (ex_valid),
    .ex_is_branch     (ex_is_branch),
    .ex_is_jal        (ex_is_jal),
    .ex_is_jalr       (ex_is_jalr),
    .ex_funct3        (ex_funct3),
    .ex_rs1_data      (ex_rs1_data),
    .ex_rs2_data      (ex_rs2_data),
    .ex_pc            (ex_pc),
    .ex_imm           (ex_imm),
    .ex_pred_taken    (ex_pred_taken),
    .ex_pred_target   (ex_pred_target),
    .if_pc            (if_pc),
    .if_pred_taken    (if_pred_taken),
    .redirect         (rif),
    .flush_if_id      (flush_if_id),
    .flush_id_ex      (flush_id_ex),
    .ex_stall         (ex_stall),
    .br_count         (br_count),
    .mispredict_count (mispredict_count)
  );

  always #5 clk = ~clk;

  int unsigned errors = 0;
  int unsigned checks = 0;

  // Behavioural model state
  int unsigned m_pht [NENT];
  longint unsigned m_br, m_mis;

  task automatic model_reset();
    for (int i = 0; i < int'(NENT); i++) m_pht[i] = 1;
    m_br  = 0;
    m_mis = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int unsigned idx_of(input logic [XLEN-1:0] pc);
    return int'((pc / 4) % NENT);
  endfunction

  task automatic idle_inputs();
    ex_valid = 0; ex_is_branch = 0; ex_is_jal = 0; ex_is_jalr = 0; ex_funct3 = 0;
    ex_rs1_data = 0; ex_rs2_data = 0; ex_pc = 0; ex_imm = 0;
    ex_pred_taken = 0; ex_pred_target = 0; if_pc = 0; rif.ready = 0;
  endtask

  // kind: 0 = conditional branch, 1 = JAL, 2 = JALR.
  // rdy_delay: cycles fetch keeps ready low once redirect_valid is up; with 0 the
  // ready line is already high during the resolve cycle.
  task automatic resolve(input int kind, input logic [2:0] f3,
                         input logic [XLEN-1:0] rs1, input logic [XLEN-1:0] rs2,
                         input logic [XLEN-1:0] pc, input logic [XLEN-1:0] imm,
                         input logic ptaken, input logic [XLEN-1:0] ptarget,
                         input int rdy_delay);
    logic            m_taken, m_mp;
    logic [XLEN-1:0] m_target, m_next;
    int unsigned     ix;
    logic signed [XLEN-1:0] s1, s2;
    s1 = rs1;
    s2 = rs2;
    ix = idx_of(pc);
    if (kind != 0) begin
      m_taken = 1;
    end else begin
      case (f3)
        3'b000:  m_taken = (rs1 == rs2);
        3'b001:  m_taken = (rs1 != rs2);
        3'b100:  m_taken = (s1 < s2);
        3'b101:  m_taken = !(s1 < s2);
        3'b110:  m_taken = (rs1 < rs2);
        3'b111:  m_taken = !(rs1 < rs2);
        default: m_taken = 0;
      endcase
    end
    if (kind == 2) m_target = ((rs1 + imm) >> 1) << 1;
    else           m_target = pc + imm;
    m_next = m_taken ? m_target : pc + 64'd4;
    m_mp   = (m_taken != ptaken) || (m_taken && (ptarget != m_target));

    ex_valid = 1; ex_is_branch = (kind == 0); ex_is_jal = (kind == 1);
    ex_is_jalr = (kind == 2); ex_funct3 = f3; ex_rs1_data = rs1; ex_rs2_data = rs2;
    ex_pc = pc; ex_imm = imm; ex_pred_taken = ptaken; ex_pred_target = ptarget;
    if_pc = pc;
    rif.ready = (rdy_delay == 0);
    #1;
    checks++;
    if (if_pred_taken !== (m_pht[ix] >= 2)) begin
      errors++;
      $display("FAIL pht_pre_update idx=%0d got=%0b exp=%0b", ix, if_pred_taken, m_pht[ix] >= 2);
    end
    step();
    ex_valid = 0;
    if (kind == 0) begin
      if (m_taken && m_pht[ix] < 3) m_pht[ix]++;
      else if (!m_taken && m_pht[ix] > 0) m_pht[ix]--;
    end
    m_br++;
    if (m_mp) m_mis++;

    checks++;
    if (br_count !== 32'(m_br)) begin
      errors++;
      $display("FAIL br_count got=%0d exp=%0d", br_count, m_br);
    end
    checks++;
    if (mispredict_count !== 32'(m_mis)) begin
      errors++;
      $display("FAIL mispredict_count got=%0d exp=%0d", mispredict_count, m_mis);
    end
    checks++;
    if (if_pred_taken !== (m_pht[ix] >= 2)) begin
      errors++;
      $display("FAIL pht_post_update idx=%0d got=%0b exp=%0b", ix, if_pred_taken, m_pht[ix] >= 2);
    end

    if (!m_mp) begin
      checks++;
      if ({rif.valid, ex_stall, flush_if_id, flush_id_ex} !== 4'b0000) begin
        errors++;
        $display("FAIL no_penalty got=%b exp=0000",
                 {rif.valid, ex_stall, flush_if_id, flush_id_ex});
      end
      rif.ready = 0;
    end else begin
      // REDIRECT phase; a resolvable instruction sits in EX but must be ignored.
      for (int c = 0; c <= rdy_delay; c++) begin
        rif.ready = (c == rdy_delay);
        ex_valid = 1; ex_is_branch = 1; ex_funct3 = 3'b000;
        checks++;
        if ({rif.valid, ex_stall, flush_if_id, flush_id_ex} !== 4'b1111 ||
            rif.pc !== m_next) begin
          errors++;
          $display("FAIL redirect_phase cyc=%0d vsff=%b pc=%h exp_pc=%h", c,
                   {rif.valid, ex_stall, flush_if_id, flush_id_ex}, rif.pc, m_next);
        end
        step();
      end
      rif.ready = 0;
      for (int c = 0; c < int'(DRN); c++) begin
        checks++;
        if ({rif.valid, ex_stall, flush_if_id, flush_id_ex} !== 4'b0111) begin
          errors++;
          $display("FAIL drain_phase cyc=%0d got=%b exp=0111", c,
                   {rif.valid, ex_stall, flush_if_id, flush_id_ex});
        end
        step();
      end
      ex_valid = 0; ex_is_branch = 0;
      checks++;
      if ({rif.valid, ex_stall, flush_if_id, flush_id_ex} !== 4'b0000 ||
          br_count !== 32'(m_br)) begin
        errors++;
        $display("FAIL back_to_idle got=%b br=%0d exp=0000 br=%0d",
                 {rif.valid, ex_stall, flush_if_id, flush_id_ex}, br_count, m_br);
      end
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    model_reset();
    repeat (3) step();
    rst_n = 1;
    step();
    checks++;
    if ({rif.valid, ex_stall, flush_if_id, flush_id_ex} !== 4'b0000 || rif.pc !== '0 ||
        br_count !== 0 || mispredict_count !== 0) begin
      errors++;
      $display("FAIL reset_outputs flags=%b pc=%h br=%0d mis=%0d exp all zero",
               {rif.valid, ex_stall, flush_if_id, flush_id_ex}, rif.pc, br_count,
               mispredict_count);
    end
    for (int i = 0; i < int'(NENT); i++) begin
      if_pc = 64'(i * 4);
      #1;
      checks++;
      if (if_pred_taken !== 1'b0) begin
        errors++;
        $display("FAIL reset_pht idx=%0d got=%0b exp=0", i, if_pred_taken);
      end
    end
  endtask

  task automatic test_beq_correct();
    resolve(0, 3'b000, 64'd5, 64'd5, 64'h1000, 64'h40, 1'b1, 64'h1040, 0);
  endtask

  task automatic test_blt_mispredict();
    resolve(0, 3'b100, '1, 64'd1, 64'h1100, 64'h80, 1'b0, 64'h0, 3);
  endtask

  task automatic test_bltu_saturate();
    for (int k = 0; k < 3; k++)
      resolve(0, 3'b110, '1, 64'd1, 64'h2000, 64'h10, 1'b1, 64'h2010, 0);
  endtask

  task automatic test_jalr();
    resolve(2, 3'b000, 64'h3001, 64'd0, 64'h3000, 64'd4, 1'b1, 64'h3004, 0);
    resolve(2, 3'b000, 64'h3001, 64'd0, 64'h3000, 64'd4, 1'b1, 64'h3000, 1);
    resolve(1, 3'b000, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFF0, 64'h20, 1'b0, 64'h0, 2);
  endtask

  task automatic test_reset_mid_redirect();
    ex_valid = 1; ex_is_branch = 1; ex_is_jal = 0; ex_is_jalr = 0; ex_funct3 = 3'b000;
    ex_rs1_data = 1; ex_rs2_data = 1; ex_pc = 64'h4000; ex_imm = 64'h8;
    ex_pred_taken = 0; ex_pred_target = 0; rif.ready = 0;
    step();
    ex_valid = 0;
    checks++;
    if (rif.valid !== 1'b1) begin
      errors++;
      $display("FAIL mid_redirect_entry got=%0b exp=1", rif.valid);
    end
    #2 rst_n = 0;
    #1;
    checks++;
    if ({rif.valid, ex_stall, flush_if_id, flush_id_ex} !== 4'b0000) begin
      errors++;
      $display("FAIL async_reset_drop got=%b exp=0000",
               {rif.valid, ex_stall, flush_if_id, flush_id_ex});
    end
    model_reset();
    step();
    rst_n = 1;
    step();
    checks++;
    if ({rif.valid, ex_stall} !== 2'b00 || br_count !== 0) begin
      errors++;
      $display("FAIL after_reset got=%b br=%0d exp=00 br=0", {rif.valid, ex_stall}, br_count);
    end
    resolve(0, 3'b001, 64'd3, 64'd4, 64'h4000, 64'h8, 1'b1, 64'h4008, 0);
    resolve(0, 3'b101, 64'd3, 64'd4, 64'h4000, 64'h8, 1'b1, 64'h4008, 1);
  endtask

  task automatic test_random();
    for (int n = 0; n < 200; n++) begin
      int              kind;
      logic [2:0]      f3;
      logic [XLEN-1:0] rs1, rs2, pc, imm, tgt;
      logic            pt;
      kind = ($urandom_range(0, 5) < 4) ? 0 : int'($urandom_range(1, 2));
      f3   = 3'($urandom);
      rs1  = {$urandom, $urandom};
      rs2  = ($urandom_range(0, 3) == 0) ? rs1 : {$urandom, $urandom};
      if ($urandom_range(0, 2) == 0) begin
        rs1 = 64'($signed(32'($urandom_range(0, 8)) - 32'sd4));
        rs2 = 64'($signed(32'($urandom_range(0, 8)) - 32'sd4));
      end
      pc   = {32'($urandom), 24'($urandom), 6'($urandom_range(0, 7)), 2'b00};
      imm  = 64'($signed(13'($urandom)));
      pt   = 1'($urandom);
      if (kind == 2) tgt = ($urandom_range(0, 1) != 0) ? ((rs1 + imm) & ~64'd1) : pc;
      else           tgt = ($urandom_range(0, 1) != 0) ? pc + imm : pc + 64'd8;
      resolve(kind, f3, rs1, rs2, pc, imm, pt, tgt, int'($urandom_range(0, 3)));
    end
  endtask

  initial begin
    test_reset();
    test_beq_correct();
    test_blt_mispredict();
    test_bltu_saturate();
    test_jalr();
    test_reset_mid_redirect();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
